// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one IMEM read per cycle and
// buffers returned words in a 2-entry queue feeding decode.
module imem_fetch_ctrl #(
    parameter int              XLEN          = 32,
    parameter int              MEM_DEPTH_BIT = 18,
    parameter logic [XLEN-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_rd_en,
    output logic [MEM_DEPTH_BIT-1:0] imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [XLEN-1:0]          inst,
    output logic [XLEN-1:0]          inst_pc,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    input  logic                     halt_req,
    output logic                     misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic [XLEN-1:0] qdata_q [2];
    logic [XLEN-1:0] qpc_q   [2];
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [1:0]      count_q, count_d;

    logic            pop;
    logic            push;
    logic            flush;
    logic            issue;
    logic            redirect_act;
    logic [2:0]      occ;
    logic [XLEN-1:0] addr_pc;

    assign inst_valid   = (count_q != 2'd0);
    assign pop          = inst_valid & inst_ready;
    assign redirect_act = redirect_valid & (state_q != S_IDLE);
    // Occupancy after this cycle's pop, counting the word still returning from IMEM.
    assign occ          = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        issue      = 1'b0;
        flush      = 1'b0;
        addr_pc    = pc_q;

        if (redirect_act) begin
            flush = 1'b1;
            if (redirect_pc[1:0] == 2'b00) begin
                misalign_d = 1'b0;
                if (halt_req) begin
                    state_d = S_HALT;
                    pc_d    = redirect_pc;
                end else begin
                    state_d = S_RUN;
                    issue   = 1'b1;
                    addr_pc = redirect_pc;
                    pc_d    = redirect_pc + XLEN'(4);
                end
            end else begin
                misalign_d = 1'b1;
                state_d    = S_ERR;
                pc_d       = redirect_pc;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_RUN;
                S_RUN: begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (occ < 3'd2) begin
                        issue = 1'b1;
                        pc_d  = pc_q + XLEN'(4);
                    end
                end
                S_HALT: begin
                    if (!halt_req) begin
                        state_d = S_RUN;
                    end
                end
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign imem_rd_en    = issue;
    assign imem_addr     = issue ? addr_pc[MEM_DEPTH_BIT+1:2] : '0;
    assign inflight_d    = issue;
    assign inflight_pc_d = addr_pc;
    // A response belonging to fetches older than a redirect is dropped.
    assign push          = inflight_q & ~flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            misalign_q    <= 1'b0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            misalign_q    <= misalign_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage carries no reset; the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            qdata_q[wr_ptr_q] <= imem_rdata;
            qpc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    assign inst         = inst_valid ? qdata_q[rd_ptr_q] : '0;
    assign inst_pc      = inst_valid ? qpc_q[rd_ptr_q]   : '0;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a queue-based fetch model predicts
// per-cycle read/valid/error outputs and the accepted instruction stream.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_rd_en;
    logic [17:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        misalign_err;

    imem_fetch_ctrl #(
        .XLEN(32),
        .MEM_DEPTH_BIT(18),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_rd_en(imem_rd_en),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt_req(halt_req),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [17:0] a);
        return 32'hA500_0000 ^ {14'b0, a} ^ {a[9:0], 22'b0};
    endfunction

    // IMEM: synchronous read, garbage on the bus when no read was issued.
    always @(posedge clk) begin
        if (imem_rd_en === 1'b1) imem_rdata <= word(imem_addr);
        else                     imem_rdata <= $urandom;
    end

    typedef struct packed {
        logic        rd;
        logic [17:0] addr;
        logic        vld;
        logic        err;
        logic [31:0] hpc;
    } cyc_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } acc_t;

    cyc_t cyc_q[$];
    acc_t acc_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 0;

    // Reference model: fetch PC, words in flight and buffered words as queues.
    logic [31:0] m_buf[$];
    bit          m_fly;
    logic [31:0] m_fly_pc;
    logic [31:0] m_pc;
    bit          m_started;
    bit          m_halted;
    bit          m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_fly     = 0;
        m_fly_pc  = '0;
        m_pc      = 32'h0;
        m_started = 0;
        m_halted  = 0;
        m_err     = 0;
    endtask

    task automatic model_step();
        cyc_t c;
        acc_t a;
        bit   pop, rd, redir;
        logic [31:0] apc;
        int   occ;
        c     = '0;
        pop   = (m_buf.size() > 0) && inst_ready;
        c.vld = (m_buf.size() > 0);
        if (c.vld) c.hpc = m_buf[0];
        c.err = m_err;
        if (pop) begin
            a.pc  = m_buf[0];
            a.ins = word(m_buf[0][19:2]);
            acc_q.push_back(a);
        end
        redir = redirect_valid && m_started;
        rd    = 0;
        apc   = m_pc;
        if (redir) begin
            if (redirect_pc[1:0] == 2'b00) begin
                m_err = 0;
                rd    = !halt_req;
                apc   = redirect_pc;
                m_pc  = halt_req ? redirect_pc : redirect_pc + 32'd4;
            end else begin
                m_err = 1;
                m_pc  = redirect_pc;
            end
            m_buf.delete();
        end else begin
            occ = m_buf.size() + int'(m_fly) - int'(pop);
            rd  = m_started && !m_err && !m_halted && !halt_req && (occ < 2);
            if (rd) m_pc = m_pc + 32'd4;
            if (pop) void'(m_buf.pop_front());
            if (m_fly) m_buf.push_back(m_fly_pc);
        end
        c.rd   = rd;
        c.addr = rd ? apc[19:2] : 18'h0;
        cyc_q.push_back(c);
        m_fly     = rd;
        m_fly_pc  = apc;
        m_halted  = m_started && halt_req;
        m_started = 1;
    endtask

    task automatic step(input bit rdy, input bit rv, input logic [31:0] rp, input bit hr);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        halt_req       = hr;
        model_step();
    endtask

    task automatic do_reset();
        cyc_t c;
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        #1;
        chk("rst_rd_en", imem_rd_en, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_err", misalign_err, 0);
        model_reset();
        c = '0;
        cyc_q.push_back(c);
        mon_en = 1;
    endtask

    task automatic run_ready(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 32'h0, 0);
    endtask

    // Monitor: compares at mid-cycle, after inputs and outputs have settled.
    always @(negedge clk) begin : monitor
        cyc_t c;
        acc_t a;
        if (mon_en) begin
            if (cyc_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL cyc_underflow actual=empty required=record at %0t", $time);
            end else begin
                c = cyc_q.pop_front();
                chk("rd_en", imem_rd_en, c.rd);
                chk("addr", imem_addr, c.addr);
                chk("inst_valid", inst_valid, c.vld);
                chk("misalign_err", misalign_err, c.err);
                if (c.vld) chk("head_pc", inst_pc, c.hpc);
            end
            if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
                if (acc_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_accept actual_pc=%0h required=none at %0t", inst_pc, $time);
                end else begin
                    a = acc_q.pop_front();
                    chk("acc_pc", inst_pc, a.pc);
                    chk("acc_inst", inst, a.ins);
                end
            end
        end
    end

    initial begin
        bit          rv, hr, rdy;
        logic [31:0] rp;
        rst_n          = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        model_reset();
        repeat (2) do_reset();

        // Streaming from reset with an always-ready consumer.
        run_ready(12);

        // Backpressure for three cycles, then release.
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0);
        run_ready(6);

        // Redirect to 0x100 while the queue is occupied.
        step(0, 0, 32'h0, 0);
        step(0, 1, 32'h0000_0100, 0);
        run_ready(6);

        // Misaligned target, then an aligned one.
        step(1, 1, 32'h0000_0102, 0);
        run_ready(4);
        step(1, 1, 32'h0000_0200, 0);
        run_ready(6);

        // Halt for five cycles mid-stream.
        for (int i = 0; i < 5; i++) step(1, 0, 32'h0, 1);
        run_ready(6);

        // Redirect together with halt, then release.
        step(1, 1, 32'h0000_0300, 1);
        step(1, 0, 32'h0, 1);
        run_ready(5);

        // PC wrap at the top of the address space.
        step(1, 1, 32'hFFFF_FFF8, 0);
        run_ready(6);

        // Reset pulse mid-stream with data in flight.
        run_ready(3);
        do_reset();
        run_ready(8);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
                rv  = ($urandom_range(0, 14) == 0);
                rp  = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 3) == 0) rp[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF8;
                hr  = ($urandom_range(0, 11) == 0);
                step(rdy, rv, rp, hr);
            end
        end
        run_ready(4);

        @(negedge clk);
        #1;
        chk("cyc_q_drained", cyc_q.size(), 0);
        chk("acc_q_drained", acc_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
